// File: rtl/sim_console_pkg.sv
// Shared encodings for the simulation console: bus commands, register offsets,
// STATUS layout and the serialiser state type.
package sim_console_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_PUTC   = 2'b01,
    CMD_FINISH = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  localparam logic [31:0] OFS_CTRL   = 32'h0;
  localparam logic [31:0] OFS_STATUS = 32'h4;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_FINI    = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic ovf, input logic fini,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = '0;
    w[ST_BUSY] = busy;
    w[ST_FULL] = full;
    w[ST_OVF]  = ovf;
    w[ST_FINI] = fini;
    w[ST_CNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/sim_console_tx_if.sv
// CPU data-bus slice seen by the console: one-cycle store/load strobes, registered load data.
interface sim_console_tx_if;
  logic        we;
  logic        re;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, re, addr, wdata, input rdata);
  modport slave  (input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 serialiser with a valid/ready byte input and a registered line output.
// state    | meaning
// TX_IDLE  | line high; takes a byte whenever valid is high
// TX_START | start bit, line low
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit, line high, then back to TX_IDLE
module uart_tx_8n1
  import sim_console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign ready = (state == TX_IDLE);
  assign busy  = (state != TX_IDLE);

  // baud_cnt counts down from BAUD_TC; every bit boundary is the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (valid) begin
            shreg    <= data;
            baud_cnt <= BAUD_TC;
            txd      <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_TC;
            bit_cnt  <= 3'd7;
            txd      <= shreg[0];
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_TC;
            if (bit_cnt == 3'd0) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
              bit_cnt <= bit_cnt - 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_cnt == '0) state <= TX_IDLE;
          else baud_cnt <= baud_cnt - 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sim_console_tx.sv
// Memory-mapped console: CTRL/STATUS decode, TX FIFO, overflow and finish tracking,
// feeding an 8N1 serialiser. sim_fini_o is raised once a finish is pending and all output drained.
module sim_console_tx
  import sim_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_8000,
  parameter int          CLKS_PER_BIT = 100,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sim_console_tx_if.slave dbus,
  output logic            txd_o,
  output logic            sim_fini_o,
  output logic            busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + OFS_CTRL;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + OFS_STATUS;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        full, empty, push_req, push, pop;
  logic        ctrl_hit, status_hit;
  logic        tx_ready, tx_busy;
  logic        overflow, fini_pending;
  logic [7:0]  tx_data;
  cmd_e        cmd;
  logic        unused_bits;

  assign ctrl_hit   = (dbus.addr[31:2] == CTRL_ADDR[31:2]);
  assign status_hit = (dbus.addr[31:2] == STATUS_ADDR[31:2]);
  assign cmd        = cmd_e'(dbus.wdata[17:16]);
  assign unused_bits = ^{dbus.addr[1:0], dbus.wdata[31:18], dbus.wdata[15:8]};

  // pointers carry one extra MSB so full and empty differ only in that bit
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop      = !empty && tx_ready;
  assign push_req = dbus.we && ctrl_hit && (cmd == CMD_PUTC);
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push     = push_req && (!full || pop);
  assign tx_data  = mem[rd_ptr[AW-1:0]];
  assign busy_o   = !empty || tx_busy;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dbus.wdata[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      fini_pending <= 1'b0;
      sim_fini_o   <= 1'b0;
      dbus.rdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push)
        overflow <= 1'b1;
      else if (dbus.we && status_hit && dbus.wdata[ST_OVF])
        overflow <= 1'b0;
      if (dbus.we && ctrl_hit && (cmd == CMD_FINISH)) fini_pending <= 1'b1;
      if (fini_pending && !busy_o) sim_fini_o <= 1'b1;
      dbus.rdata <= (dbus.re && status_hit)
                    ? pack_status(busy_o, full, overflow, fini_pending, 8'(count))
                    : '0;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk_i),
    .rst  (rst_i),
    .valid(!empty),
    .data (tx_data),
    .ready(tx_ready),
    .txd  (txd_o),
    .busy (tx_busy)
  );

endmodule

// File: tb/tb_sim_console_tx.sv
// Bench for sim_console_tx: directed and randomized bus traffic, a serial-line
// monitor that decodes frames and checks them against a queue of expected bytes.
module tb_sim_console_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE   = 32'h4000_8000;
  localparam logic [31:0] CTRL   = BASE;
  localparam logic [31:0] STATUS = BASE + 32'h4;
  localparam logic [31:0] FINISH_WORD = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, fini, busy;

  sim_console_tx_if dbus ();

  sim_console_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .dbus      (dbus),
    .txd_o     (txd),
    .sim_fini_o(fini),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int b, input int f, input int o,
                                             input int p, input int cnt);
    return 32'(cnt * 256 + p * 8 + o * 4 + f * 2 + b);
  endfunction

  // expected line level i cycles into a frame: start, 8 data bits LSB first, stop
  function automatic logic line_bit(input logic [7:0] b, input int i);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] putc_word(input logic [7:0] b);
    return {14'h0, 2'b01, 8'h00, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dbus.we = 1'b1; dbus.addr = a; dbus.wdata = d;
    tick();
    dbus.we = 1'b0; dbus.addr = '0; dbus.wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dbus.re = 1'b1; dbus.addr = a;
    tick();
    dbus.re = 1'b0; dbus.addr = '0;
    d = dbus.rdata;
  endtask

  task automatic putc(input logic [7:0] b);
    wr(CTRL, putc_word(b));
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // serial monitor: sample mid-bit relative to the detected start edge
  initial begin : monitor
    bit         active;
    int         cyc;
    int         slot;
    logic [7:0] rx;
    active = 0;
    cyc = 0;
    rx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (txd === 1'b0) begin
          active = 1;
          cyc = 0;
        end
      end else begin
        cyc++;
        if (cyc % CPB == CPB / 2) begin
          slot = cyc / CPB;
          if (slot >= 1 && slot <= 8) rx[slot-1] = txd;
          if (slot == 9) begin
            active = 0;
            check("rx_stop_bit", txd, 1);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rx_unexpected: got byte 0x%0h want no frame", rx);
            end else begin
              check("rx_byte", rx, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] r;
    int          n, act, occ, early, lows;
    logic [7:0]  by;

    dbus.we = 1'b0; dbus.re = 1'b0; dbus.addr = '0; dbus.wdata = '0;
    repeat (3) tick();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_fini", fini, 0);
    check("rst_rdata", dbus.rdata, 0);
    rst = 1'b0;
    tick();
    rd(STATUS, r);
    check("status_after_rst", r, 0);

    // exact waveform of one frame
    exp_q.push_back(8'h55);
    putc(8'h55);
    check("txd_before_pop", txd, 1);
    for (int i = 0; i < 10 * CPB; i++) begin
      tick();
      check("wave_55", txd, line_bit(8'h55, i));
    end
    check("busy_in_stop", busy, 1);
    tick();
    check("busy_after_stop", busy, 0);

    // randomized bursts, never deep enough to overflow
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        act = $urandom_range(0, 9);
        by = 8'($urandom);
        if (act < 6) begin
          exp_q.push_back(by);
          putc(by);
        end else if (act == 6) wr(CTRL, {14'h0, 2'b00, 8'h00, by});
        else if (act == 7) wr(CTRL, {14'h0, 2'b11, 8'h00, by});
        else if (act == 8) wr(BASE + 32'h8, putc_word(by));
        else wr(STATUS, {14'h0, 2'b01, 8'h00, by & 8'hFB});
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle(1000, "rand_drain");
      check("rand_all_rx", exp_q.size(), 0);
      rd(STATUS, r);
      check("rand_status", r, 0);
    end

    // three bytes waiting behind a frame in flight
    exp_q.push_back(8'h30);
    putc(8'h30);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'h31 + i));
      putc(8'(8'h31 + i));
    end
    rd(STATUS, r);
    check("status_3q", r, exp_status(1, 0, 0, 0, 3));
    rd(BASE + 32'h10, r);
    check("rd_unmapped", r, 0);
    rd(CTRL, r);
    check("rd_ctrl", r, 0);
    wait_idle(1000, "q3_drain");
    check("q3_all_rx", exp_q.size(), 0);

    // overflow: the first byte leaves one cycle after its push, nothing else for a frame time
    occ = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) occ--;
      if (occ < DEPTH) begin
        occ++;
        exp_q.push_back(8'(8'h41 + i));
      end
      putc(8'(8'h41 + i));
    end
    rd(STATUS, r);
    check("status_ovf", r, exp_status(1, 1, 1, 0, DEPTH));
    wr(STATUS, 32'h3);
    rd(STATUS, r);
    check("status_no_w1c", r, exp_status(1, 1, 1, 0, DEPTH));
    wr(STATUS, 32'h4);
    rd(STATUS, r);
    check("status_w1c", r, exp_status(1, 1, 0, 0, DEPTH));
    wait_idle(2000, "ovf_drain");
    check("ovf_all_rx", exp_q.size(), 0);

    // finish behind queued output
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    putc(8'h41);
    putc(8'h42);
    wr(CTRL, FINISH_WORD);
    n = 0;
    early = 0;
    while (busy === 1'b1 && n < 400) begin
      if (fini !== 1'b0) early++;
      tick();
      n++;
    end
    check("fini_low_while_busy", early, 0);
    check("ab_drain", busy, 0);
    check("ab_all_rx", exp_q.size(), 0);
    check("fini_at_busy_fall", fini, 0);
    tick();
    check("fini_after_busy_fall", fini, 1);
    rd(STATUS, r);
    check("status_fini", r, exp_status(0, 0, 0, 1, 0));
    check("fini_sticky", fini, 1);

    // finish with idle console
    do_reset();
    check("fini_cleared", fini, 0);
    wr(CTRL, FINISH_WORD);
    check("fini_t1", fini, 0);
    tick();
    check("fini_t2", fini, 1);
    rd(STATUS, r);
    check("status_fini_idle", r, exp_status(0, 0, 0, 1, 0));

    // reset in the middle of the data bits
    do_reset();
    exp_q.push_back(8'h00);
    putc(8'h00);
    repeat (1 + CPB + 2 * CPB) tick();
    check("mid_data_txd", txd, 0);
    check("mid_data_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_txd", txd, 1);
    check("rst_async_busy", busy, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    check("no_frame_after_rst", lows, 0);
    check("busy_after_rst", busy, 0);
    check("fini_after_rst", fini, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
